// File: rtl/mult_div_unit_if.sv
// Start/operand request and HI/LO result bundle between the datapath (master)
// and the iterative multiply/divide unit (slave).
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, a, b,
    input  busy, done, div_by_zero, hi_out, lo_out
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_by_zero, hi_out, lo_out
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: bit-serial shift-add
// multiply and restoring divide, one step per cycle, sign fix-up at the end.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  mult_div_unit_if.slave   bus
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t           state;
  state_t           state_nxt;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] opnd;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;
  logic             psign;
  logic             rsign;
  logic             dbz_q;

  logic             busy_q;
  logic             done_q;
  logic             dbz_out_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             is_div_c;
  logic             signed_op_c;
  logic             b_zero_c;
  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [PW-1:0]    mul_step_c;
  logic [WIDTH:0]   div_shift_c;
  logic [WIDTH:0]   div_trial_c;
  logic             qbit_c;
  logic [PW-1:0]    prod_c;
  logic [WIDTH-1:0] quot_c;
  logic [WIDTH-1:0] rem_c;

  // Operand decode and magnitudes for the signed variants.
  assign is_div_c    = op_q[1];
  assign signed_op_c = ~op_q[0];
  assign b_zero_c    = (b_q == '0);
  assign mag_a_c     = (signed_op_c && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b_c     = (signed_op_c && b_q[WIDTH-1]) ? -b_q : b_q;

  // One shift-add step: conditionally add multiplicand to the high half, shift right.
  assign mul_sum_c  = {1'b0, acc[PW-1:WIDTH]} + {1'b0, opnd};
  assign mul_step_c = acc[0] ? {mul_sum_c, acc[WIDTH-1:1]} : {1'b0, acc[PW-1:1]};

  // One restoring step: bring down the next dividend bit, try subtracting the divisor.
  assign div_shift_c = {rem, acc[WIDTH-1]};
  assign div_trial_c = div_shift_c - {1'b0, opnd};
  assign qbit_c      = ~div_trial_c[WIDTH];

  // Sign correction applied in FIX; overflow case wraps naturally.
  assign prod_c = psign ? -acc : acc;
  assign quot_c = psign ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_c  = rsign ? -rem : rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = PREP;
      PREP:    state_nxt = (is_div_c && b_zero_c) ? FIX : RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers: capture, prepare, iterate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      opnd  <= '0;
      acc   <= '0;
      rem   <= '0;
      cnt   <= '0;
      psign <= 1'b0;
      rsign <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q <= bus.op;
            a_q  <= bus.a;
            b_q  <= bus.b;
          end
        end
        PREP: begin
          opnd  <= is_div_c ? mag_b_c : mag_a_c;
          acc   <= {WIDTH'(0), (is_div_c ? mag_a_c : mag_b_c)};
          rem   <= '0;
          cnt   <= '0;
          psign <= signed_op_c & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          rsign <= signed_op_c & a_q[WIDTH-1];
          dbz_q <= is_div_c & b_zero_c;
        end
        RUN: begin
          cnt <= CW'(cnt + 1'b1);
          if (is_div_c) begin
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], qbit_c};
            rem            <= qbit_c ? div_trial_c[WIDTH-1:0] : div_shift_c[WIDTH-1:0];
          end else begin
            acc <= mul_step_c;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered status and HI/LO; results land on the FIX->IDLE edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      busy_q    <= (state_nxt != IDLE);
      done_q    <= (state == FIX);
      dbz_out_q <= (state == FIX) && dbz_q;
      if (state == FIX) begin
        if (dbz_q) begin
          hi_q <= a_q;
          lo_q <= '1;
        end else if (is_div_c) begin
          hi_q <= rem_c;
          lo_q <= quot_c;
        end else begin
          hi_q <= prod_c[PW-1:WIDTH];
          lo_q <= prod_c[WIDTH-1:0];
        end
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_out_q;
  assign bus.hi_out      = hi_q;
  assign bus.lo_out      = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: products, quotients, latency,
// back-to-back issue, ignored starts, divide-by-zero and asynchronous reset.
module tb_mult_div_unit;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   lat;
  int   bcyc;
  int   done_seen;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, scramble inputs after capture, wait (bounded) for done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int l, output int bc);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    step();
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    l  = 1;
    bc = int'(bus.busy);
    while (!bus.done && l < 100) begin
      step();
      l++;
      if (bus.busy) bc++;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_dbz",  64'(bus.div_by_zero), 64'(0));
    check("rst_hi",   64'(bus.hi_out), 64'(0));
    check("rst_lo",   64'(bus.lo_out), 64'(0));
    step();
    rst = 1'b1;
    step();

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcyc);
    check("multu_lat",  64'(lat), 64'(35));
    check("multu_busy", 64'(bcyc), 64'(34));
    check("multu_hi",   64'(bus.hi_out), 64'(32'hFFFF_FFFE));
    check("multu_lo",   64'(bus.lo_out), 64'(32'h0000_0001));
    check("multu_dbz",  64'(bus.div_by_zero), 64'(0));
    step();
    check("multu_done_pulse", 64'(bus.done), 64'(0));

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, bcyc);
    check("mult_hi", 64'(bus.hi_out), 64'(32'hFFFF_FFFF));
    check("mult_lo", 64'(bus.lo_out), 64'(32'hFFFF_FFF1));
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bcyc);
    check("b2b_lat", 64'(lat), 64'(35));
    check("div_lo",  64'(bus.lo_out), 64'(32'hFFFF_FFFD));
    check("div_hi",  64'(bus.hi_out), 64'(32'hFFFF_FFFF));

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcyc);
    check("ovf_lo",  64'(bus.lo_out), 64'(32'h8000_0000));
    check("ovf_hi",  64'(bus.hi_out), 64'(0));
    check("ovf_dbz", 64'(bus.div_by_zero), 64'(0));
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bcyc);
    check("divu_lo", 64'(bus.lo_out), 64'(14));
    check("divu_hi", 64'(bus.hi_out), 64'(2));
    step();

    run_op(OP_DIVU, 32'h64, 32'h0, lat, bcyc);
    check("dbz_lat",  64'(lat), 64'(3));
    check("dbz_busy", 64'(bcyc), 64'(2));
    check("dbz_flag", 64'(bus.div_by_zero), 64'(1));
    check("dbz_hi",   64'(bus.hi_out), 64'(32'h64));
    check("dbz_lo",   64'(bus.lo_out), 64'(32'hFFFF_FFFF));
    step();
    check("dbz_pulse_done", 64'(bus.done), 64'(0));
    check("dbz_pulse_flag", 64'(bus.div_by_zero), 64'(0));
    step();
    check("hold_hi", 64'(bus.hi_out), 64'(32'h64));

    // Starts at edges 5 and 20 land mid-run and must be ignored.
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.a     = 32'd6;
    bus.b     = 32'd7;
    step();
    lat = 1;
    bus.start = 1'b0;
    bus.a     = 32'd123;
    bus.b     = 32'd456;
    while (!bus.done && lat < 100) begin
      bus.start = (lat + 1 == 5) || (lat + 1 == 20);
      bus.op    = OP_DIV;
      bus.a     = bus.a + 32'd1;
      step();
      lat++;
    end
    bus.start = 1'b0;
    check("ign_lat", 64'(lat), 64'(35));
    check("ign_hi",  64'(bus.hi_out), 64'(0));
    check("ign_lo",  64'(bus.lo_out), 64'(42));
    step();
    check("ign_no_queue", 64'(bus.busy), 64'(0));

    // Asynchronous reset in the middle of a multiply.
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.a     = 32'd6;
    bus.b     = 32'd7;
    step();
    bus.start = 1'b0;
    for (int i = 2; i <= 10; i++) step();
    check("pre_rst_busy", 64'(bus.busy), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'(0));
    check("arst_done", 64'(bus.done), 64'(0));
    check("arst_hi",   64'(bus.hi_out), 64'(0));
    check("arst_lo",   64'(bus.lo_out), 64'(0));
    step();
    rst = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done || bus.busy) done_seen++;
    end
    check("arst_no_done", 64'(done_seen), 64'(0));
    run_op(OP_MULTU, 32'd3, 32'd4, lat, bcyc);
    check("post_rst_lat", 64'(lat), 64'(35));
    check("post_rst_lo",  64'(bus.lo_out), 64'(12));
    check("post_rst_hi",  64'(bus.hi_out), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide responder that owns the HI/LO pair for the MIPS core.
- The datapath initiates an operation with a start pulse, supplying an opcode and two register operands.
- The unit captures the operands, runs a bit-serial shift-add multiply or restoring divide, and returns a done pulse with HI/LO updated.
- It replaces the combinational multiplier and HI/LO registers for the multi-cycle core variant.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits and the internal product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only while idle.
- op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  input  WIDTH  rs operand; multiplicand or dividend.
- b  input  WIDTH  rt operand; multiplier or divisor.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle completion pulse.
- div_by_zero  output  1  pulses with done when a DIV/DIVU had b == 0.
- hi_out  output  WIDTH  HI register (product high half or remainder).
- lo_out  output  WIDTH  LO register (product low half or quotient).

Behaviour:
- Reset (rst low, asynchronous) forces state IDLE, busy=0, done=0, div_by_zero=0, hi_out=0, lo_out=0, and clears the counter and all working registers. This applies at any time, including mid-operation; the aborted operation leaves no trace.
- States: IDLE, PREP, RUN, FIX.
- IDLE, start=1 at a rising edge: latch op, a and b; go to PREP. Operands are not sampled again, so a and b may change afterwards.
- IDLE, start=0: remain in IDLE.
- PREP (1 cycle):
  - Form magnitudes. For MULT/DIV, take two's-complement absolute values. For MULTU/DIVU, pass operands unchanged.
  - Record result signs: product and quotient sign = a[W-1]^b[W-1]; remainder sign = a[W-1]; both forced 0 for unsigned operations.
  - If op is DIV/DIVU and b == 0, go directly to FIX. Otherwise clear the counter and go to RUN.
- RUN (exactly WIDTH cycles, counter 0..WIDTH-1):
  - Multiply: one shift-add step per cycle on the 2W-bit accumulator.
  - Divide: one restoring step per cycle, producing one quotient bit MSB-first with a W+1-bit partial remainder.
  - After the step with counter == WIDTH-1, go to FIX.
- FIX (1 cycle):
  - Apply sign correction by two's-complement negation where the recorded sign is 1.
  - Write HI/LO on the FIX->IDLE edge:
    - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
    - Divide: HI = remainder, LO = quotient.
    - Divide by zero: HI = a, LO = all ones, and div_by_zero is set.
  - Go to IDLE.
- Signed overflow: 0x80000000 / 0xFFFFFFFF yields LO = 0x80000000 and HI = 0. This is the wrapped negation; no flag is raised.
- busy = 1 in PREP, RUN and FIX, and is registered.
- Normal latency:
  - Count the start-sampling edge as edge 1.
  - busy is high for WIDTH+2 cycles.
  - HI/LO update and done rises at edge WIDTH+3 (35 for WIDTH=32).
- Divide-by-zero latency: done at edge 3 (PREP, FIX, IDLE).
- done and div_by_zero are high for exactly the first IDLE cycle after FIX.
- start is accepted in that same cycle, so back-to-back operations are allowed: the new start's PREP follows with no gap.
- start while busy is ignored; it is neither queued nor allowed to disturb the operation.
- hi_out/lo_out hold their values between operations and change only on the FIX->IDLE edge or on reset.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy high 34 cycles; done at edge 35; HI=0xFFFFFFFE, LO=0x00000001; div_by_zero=0.
- MULT a=0xFFFFFFFD (-3), b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Follow with DIV a=0xFFFFFFF9 (-7), b=2, started in the done cycle -> accepted immediately; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, div_by_zero=0. DIVU a=100, b=7 -> LO=14, HI=2.
- DIVU a=0x64, b=0 -> done and div_by_zero both high at edge 3 for one cycle; HI=0x64, LO=0xFFFFFFFF; busy high only 2 cycles.
- Start MULTU 6*7, then pulse start with a different op/a/b at edges 5 and 20, and change a/b mid-run -> both pulses ignored; result HI=0, LO=42 at edge 35.
- Start MULTU 6*7, then drive rst low for one cycle at cycle 10 -> busy, done, HI and LO go to 0 without waiting for a clock edge; state is IDLE; no done pulse follows. A fresh MULTU 3*4 afterwards gives LO=12.
